// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO request router: FSM states, default MMIO page
// and device-index width derivation.
package mmio_pkg;

  localparam logic [15:0] MMIO_PAGE_DEF = 16'h6000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEM_RD  = 3'd1,
    ST_DEV_REQ = 3'd2,
    ST_ACCEPT  = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  // Device-index field width; a single slot still gets a 1-bit field.
  function automatic int idx_width(input int num_dev);
    return (num_dev <= 2) ? 1 : $clog2(num_dev);
  endfunction

endpackage

// File: rtl/mmio_timeout_ctr.sv
// Clear/enable up-counter with a terminal-count flag; clear wins over enable.
module mmio_timeout_ctr #(
  parameter int CNT_W = 8,
  parameter int TERM  = 254
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TERM_V = CNT_W'(TERM);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TERM_V);

endmodule

// File: rtl/mmio_req_router.sv
// Routes CPU loads/stores either to the AXI memory path or to one of NUM_DEV
// MMIO device slots over a registered req/ack handshake with timeout.
module mmio_req_router
  import mmio_pkg::*;
#(
  parameter int          NUM_DEV     = 4,
  parameter logic [15:0] MMIO_PAGE   = MMIO_PAGE_DEF,
  parameter int          IDX_LSB     = 8,
  parameter int          OFF_W       = 8,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_reset_n,
  input  logic [31:0]           cpu_addr,
  input  logic                  cpu_memwrite,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  input  logic                  cpu_memread,
  output logic                  cpu_req_ready,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_rdata_valid,
  input  logic                  cpu_rdata_ready,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic                  mem_req_ready,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rdata_valid,
  output logic                  mem_rdata_ready,
  output logic [NUM_DEV-1:0]    dev_req,
  output logic                  dev_we,
  output logic [OFF_W-1:0]      dev_off,
  output logic [31:0]           dev_wdata,
  output logic [3:0]            dev_wstrb,
  input  logic [NUM_DEV-1:0]    dev_ack,
  input  logic [32*NUM_DEV-1:0] dev_rdata,
  output logic                  err_sticky,
  input  logic                  err_clr
);

  localparam int IDX_W = idx_width(NUM_DEV);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e               state_q, state_d;
  logic [NUM_DEV-1:0]   dev_req_q, dev_req_d;
  logic                 dev_we_q, dev_we_d;
  logic [OFF_W-1:0]     dev_off_q, dev_off_d;
  logic [31:0]          dev_wdata_q, dev_wdata_d;
  logic [3:0]           dev_wstrb_q, dev_wstrb_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 req, is_mmio, idx_ok, err_set;
  logic [IDX_W-1:0]     idx_in;
  logic                 ack_sel;
  logic [31:0]          rdata_sel;
  logic                 ctr_clr, ctr_en, ctr_tc;

  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign mem_wstrb = cpu_wstrb;

  assign dev_req    = dev_req_q;
  assign dev_we     = dev_we_q;
  assign dev_off    = dev_off_q;
  assign dev_wdata  = dev_wdata_q;
  assign dev_wstrb  = dev_wstrb_q;
  assign err_sticky = err_q;

  // Address decode and per-slot selection by the latched index.
  always_comb begin
    req     = cpu_memread | cpu_memwrite;
    is_mmio = (cpu_addr[31:16] == MMIO_PAGE);
    idx_in  = cpu_addr[IDX_LSB +: IDX_W];
    idx_ok  = (int'(idx_in) < NUM_DEV);
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ack_sel   = dev_ack[i];
        rdata_sel = dev_rdata[32*i +: 32];
      end
    end
  end

  mmio_timeout_ctr #(
    .CNT_W (CNT_W),
    .TERM  (TIMEOUT_CYC - 1)
  ) u_timeout (
    .clk   (cpu_clk),
    .rst_n (cpu_reset_n),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (ctr_tc)
  );

  always_comb begin
    state_d     = state_q;
    dev_req_d   = dev_req_q;
    dev_we_d    = dev_we_q;
    dev_off_d   = dev_off_q;
    dev_wdata_d = dev_wdata_q;
    dev_wstrb_d = dev_wstrb_q;
    idx_d       = idx_q;
    rdata_d     = rdata_q;
    err_set     = 1'b0;
    ctr_clr     = 1'b0;
    ctr_en      = 1'b0;
    cpu_req_ready   = 1'b0;
    cpu_rdata       = rdata_q;
    cpu_rdata_valid = 1'b0;
    mem_write       = 1'b0;
    mem_read        = 1'b0;
    mem_rdata_ready = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Simultaneous read and write is handled as a write and flagged.
        if (cpu_memread && cpu_memwrite) err_set = 1'b1;
        if (!is_mmio) begin
          mem_write     = cpu_memwrite;
          mem_read      = cpu_memread & ~cpu_memwrite;
          cpu_req_ready = mem_req_ready;
          if (mem_req_ready && cpu_memread && !cpu_memwrite) state_d = ST_MEM_RD;
        end else if (req) begin
          idx_d       = idx_in;
          dev_we_d    = cpu_memwrite;
          dev_off_d   = cpu_addr[OFF_W-1:0];
          dev_wdata_d = cpu_wdata;
          dev_wstrb_d = cpu_wstrb;
          rdata_d     = '0;
          ctr_clr     = 1'b1;
          if (idx_ok) begin
            for (int i = 0; i < NUM_DEV; i++) dev_req_d[i] = (idx_in == IDX_W'(i));
            state_d = ST_DEV_REQ;
          end else begin
            err_set = 1'b1;
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_MEM_RD: begin
        cpu_rdata       = mem_rdata;
        cpu_rdata_valid = mem_rdata_valid;
        mem_rdata_ready = cpu_rdata_ready;
        if (mem_rdata_valid && cpu_rdata_ready) state_d = ST_IDLE;
      end
      ST_DEV_REQ: begin
        ctr_en = 1'b1;
        // A real ack wins over a timeout landing in the same cycle.
        if (ack_sel) begin
          dev_req_d = '0;
          rdata_d   = dev_we_q ? 32'h0 : rdata_sel;
          state_d   = ST_ACCEPT;
        end else if (ctr_tc) begin
          dev_req_d = '0;
          rdata_d   = '0;
          err_set   = 1'b1;
          state_d   = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        cpu_req_ready = 1'b1;
        state_d       = dev_we_q ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        cpu_rdata_valid = 1'b1;
        if (cpu_rdata_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q     <= ST_IDLE;
      dev_req_q   <= '0;
      dev_we_q    <= 1'b0;
      dev_off_q   <= '0;
      dev_wdata_q <= '0;
      dev_wstrb_q <= '0;
      idx_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dev_req_q   <= dev_req_d;
      dev_we_q    <= dev_we_d;
      dev_off_q   <= dev_off_d;
      dev_wdata_q <= dev_wdata_d;
      dev_wstrb_q <= dev_wstrb_d;
      idx_q       <= idx_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mmio_req_router.sv
// Directed bench for mmio_req_router (3 slots, 16-cycle timeout) with a
// read-data scoreboard queue.
module tb_mmio_req_router;

  localparam int NUM_DEV     = 3;
  localparam int OFF_W       = 8;
  localparam int TIMEOUT_CYC = 16;

  logic                  cpu_clk = 1'b0;
  logic                  cpu_reset_n;
  logic [31:0]           cpu_addr;
  logic                  cpu_memwrite;
  logic [31:0]           cpu_wdata;
  logic [3:0]            cpu_wstrb;
  logic                  cpu_memread;
  logic                  cpu_req_ready;
  logic [31:0]           cpu_rdata;
  logic                  cpu_rdata_valid;
  logic                  cpu_rdata_ready;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_write;
  logic                  mem_read;
  logic                  mem_req_ready;
  logic [31:0]           mem_rdata;
  logic                  mem_rdata_valid;
  logic                  mem_rdata_ready;
  logic [NUM_DEV-1:0]    dev_req;
  logic                  dev_we;
  logic [OFF_W-1:0]      dev_off;
  logic [31:0]           dev_wdata;
  logic [3:0]            dev_wstrb;
  logic [NUM_DEV-1:0]    dev_ack;
  logic [32*NUM_DEV-1:0] dev_rdata;
  logic                  err_sticky;
  logic                  err_clr;

  int          n_tests;
  int          n_fail;
  int          hi;
  logic [31:0] exp_q[$];

  always #5 cpu_clk = ~cpu_clk;

  mmio_req_router #(
    .NUM_DEV     (NUM_DEV),
    .MMIO_PAGE   (16'h6000),
    .IDX_LSB     (8),
    .OFF_W       (OFF_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .cpu_clk         (cpu_clk),
    .cpu_reset_n     (cpu_reset_n),
    .cpu_addr        (cpu_addr),
    .cpu_memwrite    (cpu_memwrite),
    .cpu_wdata       (cpu_wdata),
    .cpu_wstrb       (cpu_wstrb),
    .cpu_memread     (cpu_memread),
    .cpu_req_ready   (cpu_req_ready),
    .cpu_rdata       (cpu_rdata),
    .cpu_rdata_valid (cpu_rdata_valid),
    .cpu_rdata_ready (cpu_rdata_ready),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_write       (mem_write),
    .mem_read        (mem_read),
    .mem_req_ready   (mem_req_ready),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata_ready (mem_rdata_ready),
    .dev_req         (dev_req),
    .dev_we          (dev_we),
    .dev_off         (dev_off),
    .dev_wdata       (dev_wdata),
    .dev_wstrb       (dev_wstrb),
    .dev_ack         (dev_ack),
    .dev_rdata       (dev_rdata),
    .err_sticky      (err_sticky),
    .err_clr         (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Compare the current read response against the oldest expected entry.
  task automatic sb_pop(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=<empty scoreboard>", tag, cpu_rdata);
    end else begin
      e = exp_q.pop_front();
      check(tag, cpu_rdata, e);
    end
  endtask

  task automatic nxt();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge cpu_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cpu_reset_n     = 1'b0;
    cpu_addr        = '0;
    cpu_memwrite    = 1'b0;
    cpu_wdata       = '0;
    cpu_wstrb       = '0;
    cpu_memread     = 1'b0;
    cpu_rdata_ready = 1'b0;
    mem_req_ready   = 1'b0;
    mem_rdata       = '0;
    mem_rdata_valid = 1'b0;
    dev_ack         = '0;
    dev_rdata       = {32'hCAFE_F00D, 32'h1111_1111, 32'hA5A5_A5A5};
    err_clr         = 1'b0;

    // Reset state
    repeat (2) smp();
    check("rst_dev_req", 32'(dev_req), 32'h0);
    check("rst_dev_we", 32'(dev_we), 32'h0);
    check("rst_dev_off", 32'(dev_off), 32'h0);
    check("rst_dev_wdata", dev_wdata, 32'h0);
    check("rst_dev_wstrb", 32'(dev_wstrb), 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_rvalid", 32'(cpu_rdata_valid), 32'h0);
    check("rst_err", 32'(err_sticky), 32'h0);
    nxt();
    cpu_reset_n = 1'b1;

    // Store 0x41 to slot 1 offset 0x04, ack two cycles after dev_req rises
    nxt();
    cpu_addr = 32'h6000_0104; cpu_memwrite = 1'b1; cpu_wdata = 32'h41; cpu_wstrb = 4'hF;
    smp();
    check("t1_idle_ready", 32'(cpu_req_ready), 32'h0);
    check("t1_idle_mem_write", 32'(mem_write), 32'h0);
    nxt();
    smp();
    check("t1_dev_req", 32'(dev_req), 32'h2);
    check("t1_dev_off", 32'(dev_off), 32'h04);
    check("t1_dev_wdata", dev_wdata, 32'h41);
    check("t1_dev_we", 32'(dev_we), 32'h1);
    check("t1_dev_wstrb", 32'(dev_wstrb), 32'hF);
    nxt();
    dev_ack = 3'b001;
    smp();
    check("t1_foreign_ack", 32'(dev_req), 32'h2);
    check("t1_wait_ready", 32'(cpu_req_ready), 32'h0);
    check("t1_wait_mem_write", 32'(mem_write), 32'h0);
    nxt();
    dev_ack = 3'b010;
    smp();
    check("t1_ack_cycle_ready", 32'(cpu_req_ready), 32'h0);
    nxt();
    dev_ack = '0;
    smp();
    check("t1_accept_dev_req", 32'(dev_req), 32'h0);
    check("t1_accept_ready", 32'(cpu_req_ready), 32'h1);
    nxt();
    cpu_memwrite = 1'b0;
    smp();
    check("t1_after_ready", 32'(cpu_req_ready), 32'h0);
    check("t1_after_rvalid", 32'(cpu_rdata_valid), 32'h0);
    nxt();
    smp();
    check("t1_no_reissue", 32'(dev_req), 32'h0);

    // Load from slot 2, immediate ack, CPU stalls the response 5 cycles
    nxt();
    cpu_addr = 32'h6000_0208; cpu_memread = 1'b1;
    exp_q.push_back(32'hCAFE_F00D);
    smp();
    check("t2_idle_ready", 32'(cpu_req_ready), 32'h0);
    nxt();
    dev_ack = 3'b100;
    smp();
    check("t2_dev_req", 32'(dev_req), 32'h4);
    check("t2_dev_off", 32'(dev_off), 32'h08);
    check("t2_dev_we", 32'(dev_we), 32'h0);
    nxt();
    dev_ack = '0;
    smp();
    check("t2_accept_ready", 32'(cpu_req_ready), 32'h1);
    check("t2_accept_rvalid", 32'(cpu_rdata_valid), 32'h0);
    nxt();
    cpu_memread = 1'b0; cpu_rdata_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp();
      check("t2_stall_rvalid", 32'(cpu_rdata_valid), 32'h1);
      check("t2_stall_rdata", cpu_rdata, 32'hCAFE_F00D);
      nxt();
    end
    cpu_rdata_ready = 1'b1;
    smp();
    check("t2_resp_rvalid", 32'(cpu_rdata_valid), 32'h1);
    sb_pop("t2_resp_rdata");
    nxt();
    cpu_rdata_ready = 1'b0;
    smp();
    check("t2_done_rvalid", 32'(cpu_rdata_valid), 32'h0);

    // Normal-memory load passes through; request during MEM_RD is held off
    nxt();
    cpu_addr = 32'h0000_1000; cpu_memread = 1'b1; mem_req_ready = 1'b1;
    exp_q.push_back(32'h1234_5678);
    smp();
    check("t3_mem_read", 32'(mem_read), 32'h1);
    check("t3_mem_write", 32'(mem_write), 32'h0);
    check("t3_mem_addr", mem_addr, 32'h0000_1000);
    check("t3_cpu_ready", 32'(cpu_req_ready), 32'h1);
    nxt();
    cpu_addr = 32'h0000_2000;
    smp();
    check("t3_busy_ready", 32'(cpu_req_ready), 32'h0);
    check("t3_busy_mem_read", 32'(mem_read), 32'h0);
    check("t3_busy_rvalid", 32'(cpu_rdata_valid), 32'h0);
    check("t3_busy_dev_req", 32'(dev_req), 32'h0);
    nxt();
    mem_rdata = 32'h1234_5678; mem_rdata_valid = 1'b1; cpu_rdata_ready = 1'b1;
    smp();
    check("t3_rvalid", 32'(cpu_rdata_valid), 32'h1);
    check("t3_mem_rdata_ready", 32'(mem_rdata_ready), 32'h1);
    sb_pop("t3_rdata");
    nxt();
    cpu_memread = 1'b0; mem_rdata_valid = 1'b0; cpu_rdata_ready = 1'b0; mem_req_ready = 1'b0;
    smp();
    check("t3_done_rvalid", 32'(cpu_rdata_valid), 32'h0);
    check("t3_done_mem_rdy", 32'(mem_rdata_ready), 32'h0);

    // Unmapped slot 3: no dev_req, error flagged, zero data returned
    nxt();
    cpu_addr = 32'h6000_0300; cpu_memread = 1'b1;
    exp_q.push_back(32'h0);
    smp();
    check("t4_idle_ready", 32'(cpu_req_ready), 32'h0);
    check("t4_err_before", 32'(err_sticky), 32'h0);
    nxt();
    smp();
    check("t4_no_dev_req", 32'(dev_req), 32'h0);
    check("t4_accept_ready", 32'(cpu_req_ready), 32'h1);
    check("t4_err_set", 32'(err_sticky), 32'h1);
    nxt();
    cpu_memread = 1'b0; cpu_rdata_ready = 1'b1;
    smp();
    check("t4_rvalid", 32'(cpu_rdata_valid), 32'h1);
    sb_pop("t4_rdata");
    nxt();
    cpu_rdata_ready = 1'b0; err_clr = 1'b1;
    nxt();
    err_clr = 1'b0;
    smp();
    check("t4_err_cleared", 32'(err_sticky), 32'h0);
    nxt();
    cpu_addr = 32'h6000_0300; cpu_memwrite = 1'b1; err_clr = 1'b1;
    nxt();
    err_clr = 1'b0;
    smp();
    check("t4_set_beats_clr", 32'(err_sticky), 32'h1);
    check("t4_wr_accept", 32'(cpu_req_ready), 32'h1);
    nxt();
    cpu_memwrite = 1'b0; err_clr = 1'b1;
    nxt();
    err_clr = 1'b0;
    smp();
    check("t4_err_cleared2", 32'(err_sticky), 32'h0);

    // Slot 0 never acks: timeout after TIMEOUT_CYC cycles of dev_req
    nxt();
    cpu_addr = 32'h6000_0010; cpu_memread = 1'b1;
    exp_q.push_back(32'h0);
    nxt();
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      smp();
      if (i == 0) check("t5_onehot", 32'(dev_req), 32'h1);
      if (dev_req == '0) break;
      hi++;
      nxt();
    end
    check("t5_req_cycles", 32'(hi), 32'(TIMEOUT_CYC));
    check("t5_accept_ready", 32'(cpu_req_ready), 32'h1);
    check("t5_err", 32'(err_sticky), 32'h1);
    check("t5_dev_off", 32'(dev_off), 32'h10);
    nxt();
    cpu_memread = 1'b0; cpu_rdata_ready = 1'b1;
    smp();
    check("t5_rvalid", 32'(cpu_rdata_valid), 32'h1);
    sb_pop("t5_rdata");
    nxt();
    cpu_rdata_ready = 1'b0;

    // Asynchronous reset in DEV_REQ, then normal memory traffic
    cpu_addr = 32'h6000_0104; cpu_memwrite = 1'b1; cpu_wdata = 32'h55;
    nxt();
    smp();
    check("t6_dev_req", 32'(dev_req), 32'h2);
    cpu_reset_n = 1'b0;
    #1;
    check("t6_async_dev_req", 32'(dev_req), 32'h0);
    check("t6_async_wdata", dev_wdata, 32'h0);
    check("t6_async_err", 32'(err_sticky), 32'h0);
    cpu_memwrite = 1'b0;
    nxt();
    cpu_reset_n = 1'b1;
    nxt();
    cpu_addr = 32'h0000_2000; cpu_memwrite = 1'b1; cpu_wdata = 32'hDEAD_BEEF;
    cpu_wstrb = 4'h3; mem_req_ready = 1'b1;
    smp();
    check("t6_mem_write", 32'(mem_write), 32'h1);
    check("t6_mem_addr", mem_addr, 32'h0000_2000);
    check("t6_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t6_mem_wstrb", 32'(mem_wstrb), 32'h3);
    check("t6_cpu_ready", 32'(cpu_req_ready), 32'h1);
    check("t6_no_dev_req", 32'(dev_req), 32'h0);
    nxt();
    cpu_memwrite = 1'b0;
    smp();
    check("t6_wr_done", 32'(mem_write), 32'h0);
    check("t6_wr_rvalid", 32'(cpu_rdata_valid), 32'h0);

    // Read and write together: handled as a write, error flagged
    nxt();
    cpu_addr = 32'h0000_3000; cpu_memread = 1'b1; cpu_memwrite = 1'b1;
    smp();
    check("t7_as_write", 32'(mem_write), 32'h1);
    check("t7_no_read", 32'(mem_read), 32'h0);
    nxt();
    cpu_memread = 1'b0; cpu_memwrite = 1'b0;
    smp();
    check("t7_err", 32'(err_sticky), 32'h1);
    check("t7_stay_idle", 32'(cpu_req_ready), 32'h1);
    check("t7_rvalid", 32'(cpu_rdata_valid), 32'h0);

    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_req_router.md
Name: mmio_req_router

Overview:
- Parametrised data-side request router placed between custom_cpu's memory port and mem_if_wrapper.
- Decodes each CPU load/store by address:
  - Normal memory: passed through to the AXI memory path.
  - MMIO page: routed to one of NUM_DEV device slots (slot 0 = UART) over a registered req/ack interface.
- Generalises the fixed single-UART decode to N devices, and adds per-request timeout, unmapped-slot handling and a sticky error flag.

Parameters:
- NUM_DEV, 4, number of MMIO device slots (1..16).
- MMIO_PAGE, 16'h6000, value of Address[31:16] that selects MMIO.
- IDX_LSB, 8, LSB of the device-index field in Address; the index is Address[IDX_LSB +: IDX_W], with IDX_W = clog2(NUM_DEV), minimum 1.
- OFF_W, 8, width of the in-device offset; dev_off = Address[OFF_W-1:0].
- TIMEOUT_CYC, 255, maximum cycles in DEV_REQ before forced completion (>= 2).

Ports:
- cpu_clk  in  1  clock
- cpu_reset_n  in  1  asynchronous, active-low reset
- cpu_addr  in  32  CPU Address
- cpu_memwrite  in  1  CPU MemWrite
- cpu_wdata  in  32  CPU Write_data
- cpu_wstrb  in  4  CPU Write_strb
- cpu_memread  in  1  CPU MemRead
- cpu_req_ready  out  1  Mem_Req_Ready to CPU
- cpu_rdata  out  32  Read_data to CPU
- cpu_rdata_valid  out  1  Read_data_Valid to CPU
- cpu_rdata_ready  in  1  Read_data_Ready from CPU
- mem_addr, mem_wdata, mem_wstrb, mem_write, mem_read  out  32/32/4/1/1  request to mem_if_wrapper
- mem_req_ready  in  1  from mem_if_wrapper
- mem_rdata  in  32  from mem_if_wrapper
- mem_rdata_valid  in  1  from mem_if_wrapper
- mem_rdata_ready  out  1  to mem_if_wrapper
- dev_req  out  NUM_DEV  one-hot registered request
- dev_we  out  1  1 = write
- dev_off  out  OFF_W  latched offset
- dev_wdata  out  32  latched write data
- dev_wstrb  out  4  latched write strobe
- dev_ack  in  NUM_DEV  per-device completion pulse
- dev_rdata  in  32*NUM_DEV  per-device read data; slot i occupies bits [32i+31:32i]
- err_sticky  out  1  error flag
- err_clr  in  1  clears err_sticky

Behaviour:
- Reset (asynchronous, cpu_reset_n=0): state=IDLE; the following outputs are 0: dev_req, dev_we, dev_off, dev_wdata, dev_wstrb, cpu_rdata, err_sticky and all latches. Reset mid-transaction abandons it with no response.
- Request: req = cpu_memread | cpu_memwrite. is_mmio = cpu_addr[31:16]==MMIO_PAGE.
- Both cpu_memread and cpu_memwrite high: treat as a write and set err_sticky.
- States: IDLE, MEM_RD, DEV_REQ, ACCEPT, RESP.
- IDLE with a memory request:
  - mem_* driven combinationally from cpu_*; cpu_req_ready = mem_req_ready.
  - Write handshake: stay in IDLE.
  - Read handshake: go to MEM_RD.
- MEM_RD:
  - cpu_rdata=mem_rdata, cpu_rdata_valid=mem_rdata_valid, mem_rdata_ready=cpu_rdata_ready.
  - On valid & ready: go to IDLE.
  - New CPU requests are not accepted (cpu_req_ready=0).
- mem_write and mem_read are 0 whenever the state is not IDLE or is_mmio=1.
- IDLE with an MMIO request:
  - cpu_req_ready=0.
  - Latch idx, dev_we, dev_off, dev_wdata and dev_wstrb; clear the timeout counter.
  - idx < NUM_DEV: set dev_req[idx] and go to DEV_REQ.
  - Otherwise (unmapped slot): set err_sticky, latched rdata=0, go directly to ACCEPT.
- DEV_REQ:
  - dev_req held; counter increments each cycle.
  - On dev_ack[idx]: clear dev_req, latch rdata = dev_rdata slot idx (reads only), go to ACCEPT.
  - Counter == TIMEOUT_CYC-1 with no ack: clear dev_req, rdata=0, set err_sticky, go to ACCEPT.
  - dev_ack bits of other slots are ignored.
- ACCEPT:
  - cpu_req_ready=1 for exactly one cycle; the CPU holds its request stable until then.
  - Then go to RESP for a read, IDLE for a write.
- RESP:
  - cpu_rdata_valid=1, cpu_rdata=latched data, held until cpu_rdata_ready; then go to IDLE.
- Latency (dev_ack in cycle k after entry to DEV_REQ at cycle 1):
  - cpu_req_ready at cycle k+1.
  - Read data valid from cycle k+2.
  - Minimum MMIO write turnaround = 3 cycles.
- err_sticky: set has priority over a simultaneous err_clr.
- Outside RESP and MEM_RD: cpu_rdata_valid=0.

Decomposition:
- Shared package mmio_pkg: state encoding constants, MMIO_PAGE default, IDX_W derivation function.
- One natural sub-module, mmio_timeout_ctr: a clear/enable counter with a terminal-count flag, also reusable by future bus bridges.

Test Plan:
- Store 0x41 to 0x6000_0104 (slot 1, off 0x04); dev_ack[1] two cycles after dev_req → dev_req=4'b0010, dev_off=0x04, dev_wdata=0x41, cpu_req_ready pulses one cycle later, then IDLE; no mem_write.
- Load 0x6000_0208, dev_rdata slot2=0xCAFE_F00D, ack in the first cycle → cpu_rdata_valid from cycle 3 with 0xCAFEF00D; with cpu_rdata_ready held low 5 cycles, valid and data stay stable.
- Load 0x0000_1000 with a stubbed mem_if returning 0x1234_5678 → passes through unchanged, no dev_req; a CPU request during MEM_RD is not accepted.
- NUM_DEV=3, load 0x6000_0300 → no dev_req, err_sticky=1, data 0 returned; err_clr pulse clears it, and err_clr coincident with a new error leaves it 1.
- Slot 0 never acks, TIMEOUT_CYC=16 → dev_req high exactly 16 cycles, then cpu_req_ready pulse, rdata 0, err_sticky=1.
- Assert cpu_reset_n=0 during DEV_REQ → dev_req=0 immediately (asynchronous); after release the next memory store passes through normally.
